// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register indices, PC increment and MEM/WB pipeline register layout
package cpu_pkg;
  localparam int XLEN = 64;
  localparam logic [4:0] REG_ZERO = 5'd31;
  localparam logic [4:0] REG_LINK = 5'd30;
  localparam int PC_INC = 4;
  typedef struct packed {
    logic            valid;
    logic            RegWrite;
    logic            MemtoReg;
    logic            BLsignal;
    logic [4:0]      Rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc;
  } mem_wb_t;
endpackage

// File: rtl/mux64_2x1.sv
// mux64_2x1: two-input datapath multiplexer, in1 selected when sel is high
module mux64_2x1 #(
  parameter int W = 64
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/wb_bypass.sv
// wb_bypass: forwards the pending write-back value to both ID operand reads
module wb_bypass #(
  parameter int DATA_W = 64
) (
  input  logic              i_we,
  input  logic [4:0]        i_rd,
  input  logic [DATA_W-1:0] i_dw,
  input  logic [4:0]        i_ra,
  input  logic [4:0]        i_rb,
  input  logic [DATA_W-1:0] i_da,
  input  logic [DATA_W-1:0] i_db,
  output logic [DATA_W-1:0] o_da,
  output logic [DATA_W-1:0] o_db
);
  // X31 never matches because the write enable is already suppressed for it
  always_comb begin
    o_da = (i_we && i_rd == i_ra) ? i_dw : i_da;
    o_db = (i_we && i_rd == i_rb) ? i_dw : i_db;
  end
endmodule

// File: rtl/data_wb.sv
// data_wb: MEM/WB register, write-back select, regfile write port, bypass and retire count
module data_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic              mem_BLsignal,
  input  logic [4:0]        mem_Rd,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic [4:0]        id_Ra,
  input  logic [4:0]        id_Rb,
  input  logic [DATA_W-1:0] rf_Da,
  input  logic [DATA_W-1:0] rf_Db,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_Rd,
  output logic [DATA_W-1:0] wb_Dw,
  output logic [DATA_W-1:0] Da_out,
  output logic [DATA_W-1:0] Db_out,
  output logic [CNT_W-1:0]  retired
);
  mem_wb_t           r_wb;
  logic [CNT_W-1:0]  r_retired;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_link;
  // Flush turns the slot into a bubble (priority over stall); stall holds every field
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wb <= '0;
    else if (flush) r_wb.valid <= 1'b0;
    else if (!stall) r_wb <= '{valid: mem_valid, RegWrite: mem_RegWrite, MemtoReg: mem_MemtoReg,
                               BLsignal: mem_BLsignal, Rd: mem_Rd, alu: mem_alu,
                               rdata: mem_rdata, pc: mem_pc};
  end
  // The occupant retires when it leaves WB: on an unstalled edge or when flushed; saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retired <= '0;
    else if (r_wb.valid && (!stall || flush) && r_retired != '1) r_retired <= r_retired + CNT_W'(1);
  end
  assign w_link = r_wb.pc + DATA_W'(PC_INC);
  mux64_2x1 #(.W(DATA_W)) u_mux_mem (.in0(r_wb.alu), .in1(r_wb.rdata), .sel(r_wb.MemtoReg), .out(w_mem_data));
  mux64_2x1 #(.W(DATA_W)) u_mux_link (.in0(w_mem_data), .in1(w_link), .sel(r_wb.BLsignal), .out(wb_Dw));
  // BL always targets the link register; writes aimed at X31 are dropped
  always_comb begin
    wb_Rd       = r_wb.BLsignal ? REG_LINK : r_wb.Rd;
    wb_RegWrite = r_wb.valid && (r_wb.RegWrite || r_wb.BLsignal) && wb_Rd != REG_ZERO;
  end
  wb_bypass #(.DATA_W(DATA_W)) u_bypass (
    .i_we(wb_RegWrite), .i_rd(wb_Rd), .i_dw(wb_Dw), .i_ra(id_Ra), .i_rb(id_Rb),
    .i_da(rf_Da), .i_db(rf_Db), .o_da(Da_out), .o_db(Db_out)
  );
  assign retired = r_retired;
endmodule

// File: tb/tb_data_wb.sv
// tb_data_wb: directed literal checks plus randomized run against a behavioural write-back model
module tb_data_wb;
  logic        clk = 0, reset = 1, stall = 0, flush = 0;
  logic        mem_valid = 0, mem_RegWrite = 0, mem_MemtoReg = 0, mem_BLsignal = 0;
  logic [4:0]  mem_Rd = 0, id_Ra = 0, id_Rb = 0;
  logic [63:0] mem_alu = 0, mem_rdata = 0, mem_pc = 0, rf_Da = 0, rf_Db = 0;
  logic        wb_RegWrite;
  logic [4:0]  wb_Rd;
  logic [63:0] wb_Dw, Da_out, Db_out;
  logic [31:0] retired;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;

  data_wb #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .mem_BLsignal(mem_BLsignal),
    .mem_Rd(mem_Rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc(mem_pc),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .rf_Da(rf_Da), .rf_Db(rf_Db), .wb_RegWrite(wb_RegWrite),
    .wb_Rd(wb_Rd), .wb_Dw(wb_Dw), .Da_out(Da_out), .Db_out(Db_out), .retired(retired)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently in WB (decoded to its write effect) and the retire count
  bit          m_valid, m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_dw;
  longint      m_ret;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_dw = 0; m_ret = 0;
    end else begin
      if (m_valid && (!stall || flush)) m_ret = (m_ret == 64'hFFFF_FFFF) ? m_ret : m_ret + 1;
      if (flush) begin
        m_valid = 0; m_we = 0;
      end else if (!stall) begin
        m_valid = mem_valid;
        m_rd    = mem_BLsignal ? 5'd30 : mem_Rd;
        m_dw    = mem_BLsignal ? mem_pc + 64'd4 : (mem_MemtoReg ? mem_rdata : mem_alu);
        m_we    = mem_valid && (mem_RegWrite || mem_BLsignal) && m_rd != 5'd31;
      end
    end
  end

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; a bubble still must present a quiet port
  always @(negedge clk) if (chk) begin
    check("we", {63'd0, wb_RegWrite}, {63'd0, m_we});
    if (m_we) begin
      check("rd", {59'd0, wb_Rd}, {59'd0, m_rd});
      check("dw", wb_Dw, m_dw);
    end
    check("da", Da_out, (m_we && m_rd == id_Ra) ? m_dw : rf_Da);
    check("db", Db_out, (m_we && m_rd == id_Rb) ? m_dw : rf_Db);
    check("retired", {32'd0, retired}, m_ret[63:0]);
  end

  task automatic drive(input logic v, rw, mtr, bl, input logic [4:0] rd,
                       input logic [63:0] alu, rdata, pc);
    @(negedge clk); #1;
    mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = mtr; mem_BLsignal = bl;
    mem_Rd = rd; mem_alu = alu; mem_rdata = rdata; mem_pc = pc;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rf_Da = 64'hAA; rf_Db = 64'hBB; id_Ra = 0; id_Rb = 0;
    #12;
    check("rst_we", {63'd0, wb_RegWrite}, 64'd0);
    check("rst_dw", wb_Dw, 64'd0);
    check("rst_da", Da_out, 64'hAA);
    check("rst_ret", {32'd0, retired}, 64'd0);
    @(negedge clk); #1; reset = 0; chk = 1;
    drive(1, 1, 0, 0, 5, 64'h1234, 0, 0); tick;
    check("alu_we", {63'd0, wb_RegWrite}, 64'd1);
    check("alu_rd", {59'd0, wb_Rd}, 64'd5);
    check("alu_dw", wb_Dw, 64'h1234);
    check("alu_ret0", {32'd0, retired}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    check("alu_ret1", {32'd0, retired}, 64'd1);
    drive(1, 1, 1, 0, 9, 64'h77, 64'hDEAD, 0); tick;
    check("ld_dw", wb_Dw, 64'hDEAD);
    check("ld_rd", {59'd0, wb_Rd}, 64'd9);
    drive(1, 0, 0, 1, 4, 64'h77, 64'h88, 64'h100); tick;
    check("bl_rd", {59'd0, wb_Rd}, 64'd30);
    check("bl_dw", wb_Dw, 64'h104);
    check("bl_we", {63'd0, wb_RegWrite}, 64'd1);
    drive(1, 1, 0, 0, 31, 64'd7, 0, 0); tick;
    id_Ra = 31; rf_Da = 0; #1;
    check("x31_we", {63'd0, wb_RegWrite}, 64'd0);
    check("x31_da", Da_out, 64'd0);
    check("x31_ret", {32'd0, retired}, 64'd3);
    id_Ra = 3; id_Rb = 4; rf_Da = 64'h11; rf_Db = 64'h22;
    drive(1, 1, 0, 0, 3, 64'h55, 0, 0); tick;
    check("byp_da", Da_out, 64'h55);
    check("byp_db", Db_out, 64'h22);
    check("byp_ret", {32'd0, retired}, 64'd4);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 7, 64'h99 + 64'(i), 0, 0); tick;
    end
    check("stall_rd", {59'd0, wb_Rd}, 64'd3);
    check("stall_dw", wb_Dw, 64'h55);
    check("stall_we", {63'd0, wb_RegWrite}, 64'd1);
    check("stall_ret", {32'd0, retired}, 64'd4);
    flush = 1;
    drive(1, 1, 0, 0, 8, 64'h66, 0, 0); tick;
    check("sf_we", {63'd0, wb_RegWrite}, 64'd0);
    check("sf_ret", {32'd0, retired}, 64'd5);
    stall = 0; flush = 0;
    drive(1, 0, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF); tick;
    check("wrap_dw", wb_Dw, 64'd3);
    check("wrap_rd", {59'd0, wb_Rd}, 64'd30);
    drive(1, 1, 0, 0, 2, 64'hABC, 0, 0); tick;
    check("pre_rst_we", {63'd0, wb_RegWrite}, 64'd1);
    #2; reset = 1; #1;
    check("arst_we", {63'd0, wb_RegWrite}, 64'd0);
    check("arst_ret", {32'd0, retired}, 64'd0);
    check("arst_dw", wb_Dw, 64'd0);
    @(negedge clk); #1; reset = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      mem_valid    = ($urandom_range(0, 9) != 0);
      mem_RegWrite = $urandom_range(0, 1);
      mem_MemtoReg = $urandom_range(0, 1);
      mem_BLsignal = ($urandom_range(0, 7) == 0);
      mem_Rd       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      mem_alu      = {$urandom, $urandom};
      mem_rdata    = {$urandom, $urandom};
      mem_pc       = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      id_Ra        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      id_Rb        = ($urandom_range(0, 3) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
      rf_Da        = {$urandom, $urandom};
      rf_Db        = {$urandom, $urandom};
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk); #1; reset = 0;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
